// File: rtl/f_reg_wb_arbiter_pkg.sv
// rtl/f_reg_wb_arbiter_pkg.sv - shared constants and helpers for the FP writeback arbiter
package f_reg_wb_arbiter_pkg;

  localparam int FWB_REQ_FPU  = 0;
  localparam int FWB_REQ_LOAD = 1;
  localparam int FWB_REQ_MOVE = 2;

  localparam int FWB_NUM_REQ    = 3;
  localparam int FWB_DATA_W     = 32;
  localparam int FWB_ADDR_W     = 5;
  localparam int FWB_CNT_W      = 16;
  localparam int FWB_GRANT_ID_W = 3;

  // Requester count is capped at 8, so an 8-bit popcount covers every build.
  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] c;
    c = '0;
    for (int i = 0; i < 8; i++) begin
      c = c + {3'b000, v[i]};
    end
    return c;
  endfunction

endpackage

// File: rtl/f_reg_wb_arbiter_if.sv
// rtl/f_reg_wb_arbiter_if.sv - requester and register-file write bundle for the FP writeback arbiter
interface f_reg_wb_arbiter_if #(
  parameter int NUM_REQ = 3,
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5
);

  logic [NUM_REQ-1:0]        REQ_VALID;
  logic [NUM_REQ*ADDR_W-1:0] REQ_ADDR;
  logic [NUM_REQ*DATA_W-1:0] REQ_DATA;
  logic [NUM_REQ-1:0]        REQ_READY;
  logic                      WR_EN;
  logic [ADDR_W-1:0]         WR_ADDR;
  logic [DATA_W-1:0]         WR_DATA;
  logic [2:0]                GRANT_ID;

  modport master (
    output REQ_VALID, REQ_ADDR, REQ_DATA,
    input  REQ_READY, WR_EN, WR_ADDR, WR_DATA, GRANT_ID
  );

  modport slave (
    input  REQ_VALID, REQ_ADDR, REQ_DATA,
    output REQ_READY, WR_EN, WR_ADDR, WR_DATA, GRANT_ID
  );

endinterface

// File: rtl/f_reg_wb_arbiter_rr_pick.sv
// rtl/f_reg_wb_arbiter_rr_pick.sv - combinational round-robin priority picker starting at ptr
module rr_pick #(
  parameter int N     = 3,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  int               j;
  logic [IDX_W-1:0] j_idx;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    j     = 0;
    j_idx = '0;
    for (int k = 0; k < N; k++) begin
      j = int'(ptr) + k;
      if (j >= N) begin
        j = j - N;
      end
      j_idx = IDX_W'(j);
      if (!any && req[j_idx]) begin
        any          = 1'b1;
        grant[j_idx] = 1'b1;
        idx          = j_idx;
      end
    end
  end

endmodule

// File: rtl/f_reg_wb_arbiter.sv
// rtl/f_reg_wb_arbiter.sv - round-robin arbiter for the single FP register file write port
module f_reg_wb_arbiter
  import f_reg_wb_arbiter_pkg::*;
#(
  parameter int NUM_REQ = FWB_NUM_REQ,
  parameter int DATA_W  = FWB_DATA_W,
  parameter int ADDR_W  = FWB_ADDR_W,
  parameter int CNT_W   = FWB_CNT_W
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic                 FLUSH,
  f_reg_wb_arbiter_if.slave    bus,
  output logic [CNT_W-1:0]     STALL_CNT
);

  localparam int IDX_W = $clog2(NUM_REQ);

  logic [IDX_W-1:0]   ptr;
  logic [NUM_REQ-1:0] pick_grant;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_any;
  logic               blocked;
  logic               transfer;
  logic [IDX_W-1:0]   ptr_next;
  logic [ADDR_W-1:0]  sel_addr;
  logic [DATA_W-1:0]  sel_data;
  logic [NUM_REQ-1:0] waiting;
  logic [3:0]         wait_cnt;
  logic [CNT_W:0]     stall_sum;
  logic [CNT_W-1:0]   stall_next;

  rr_pick #(
    .N     (NUM_REQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .req   (bus.REQ_VALID),
    .ptr   (ptr),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  assign blocked       = FLUSH | RESET;
  assign transfer      = pick_any & ~blocked;
  assign bus.REQ_READY = blocked ? '0 : pick_grant;
  assign ptr_next      = (pick_idx == IDX_W'(NUM_REQ - 1)) ? '0 : pick_idx + IDX_W'(1);

  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_grant[i]) begin
        sel_addr = bus.REQ_ADDR[i*ADDR_W +: ADDR_W];
        sel_data = bus.REQ_DATA[i*DATA_W +: DATA_W];
      end
    end
  end

  // At most 8 waiters per cycle, so one carry bit is enough to detect overflow.
  assign waiting    = bus.REQ_VALID & ~bus.REQ_READY;
  assign wait_cnt   = popcount8(8'(waiting));
  assign stall_sum  = {1'b0, STALL_CNT} + (CNT_W + 1)'(wait_cnt);
  assign stall_next = stall_sum[CNT_W] ? {CNT_W{1'b1}} : stall_sum[CNT_W-1:0];

  always_ff @(posedge CLK) begin
    if (RESET) begin
      ptr          <= '0;
      bus.WR_EN    <= 1'b0;
      bus.WR_ADDR  <= '0;
      bus.WR_DATA  <= '0;
      bus.GRANT_ID <= '0;
      STALL_CNT    <= '0;
    end else begin
      bus.WR_EN <= transfer;
      STALL_CNT <= stall_next;
      if (transfer) begin
        ptr          <= ptr_next;
        bus.WR_ADDR  <= sel_addr;
        bus.WR_DATA  <= sel_data;
        bus.GRANT_ID <= 3'(pick_idx);
      end
    end
  end

endmodule

// File: tb/tb_f_reg_wb_arbiter.sv
// tb/tb_f_reg_wb_arbiter.sv - directed self-checking bench for f_reg_wb_arbiter
module tb_f_reg_wb_arbiter;
  import f_reg_wb_arbiter_pkg::*;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        FLUSH;
  logic        FLUSH2;
  logic [15:0] STALL_CNT;
  logic [3:0]  STALL_CNT2;
  int          passed = 0;
  int          total  = 0;

  always #5 CLK = ~CLK;

  f_reg_wb_arbiter_if #(.NUM_REQ(3), .DATA_W(32), .ADDR_W(5)) bus ();
  f_reg_wb_arbiter_if #(.NUM_REQ(3), .DATA_W(32), .ADDR_W(5)) bus2 ();

  f_reg_wb_arbiter #(.NUM_REQ(3), .DATA_W(32), .ADDR_W(5), .CNT_W(16)) u_dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .FLUSH     (FLUSH),
    .bus       (bus.slave),
    .STALL_CNT (STALL_CNT)
  );

  f_reg_wb_arbiter #(.NUM_REQ(3), .DATA_W(32), .ADDR_W(5), .CNT_W(4)) u_dut_sat (
    .CLK       (CLK),
    .RESET     (RESET),
    .FLUSH     (FLUSH2),
    .bus       (bus2.slave),
    .STALL_CNT (STALL_CNT2)
  );

  // Requester protocol: once valid, hold valid and payload until accepted.
  logic [2:0]  pend_q = '0;
  logic [14:0] addr_q = '0;
  logic [95:0] data_q = '0;
  always @(posedge CLK) begin
    if (!RESET) begin
      for (int i = 0; i < 3; i++) begin
        if (pend_q[i] && (!bus.REQ_VALID[i] || bus.REQ_ADDR[i*5 +: 5] !== addr_q[i*5 +: 5]
                          || bus.REQ_DATA[i*32 +: 32] !== data_q[i*32 +: 32]))
          $error("requester %0d dropped or changed before acceptance", i);
      end
    end
    pend_q <= RESET ? 3'b000 : (bus.REQ_VALID & ~bus.REQ_READY);
    addr_q <= bus.REQ_ADDR;
    data_q <= bus.REQ_DATA;
  end

  task automatic step;
    @(posedge CLK);
    #1;
  endtask

  task automatic set_req(input int i, input logic [4:0] a, input logic [31:0] d);
    bus.REQ_ADDR[i*5 +: 5]   = a;
    bus.REQ_DATA[i*32 +: 32] = d;
  endtask

  task automatic do_reset;
    RESET = 1'b1;
    FLUSH = 1'b0;
    FLUSH2 = 1'b0;
    bus.REQ_VALID = '0;
    bus2.REQ_VALID = '0;
    step();
    RESET = 1'b0;
  endtask

  task automatic test_reset;
    RESET = 1'b1;
    FLUSH = 1'b0;
    FLUSH2 = 1'b0;
    bus.REQ_ADDR = '1;
    bus.REQ_DATA = '1;
    bus2.REQ_ADDR = '0;
    bus2.REQ_DATA = '0;
    bus.REQ_VALID = 3'b111;
    bus2.REQ_VALID = 3'b000;
    step();
    step();
    total++; if (bus.REQ_READY !== 3'b000) $display("FAIL rst_ready got %b want 000", bus.REQ_READY); else passed++;
    total++; if (bus.WR_EN !== 1'b0) $display("FAIL rst_wr_en got %b want 0", bus.WR_EN); else passed++;
    total++; if (bus.WR_ADDR !== 5'd0) $display("FAIL rst_wr_addr got %0d want 0", bus.WR_ADDR); else passed++;
    total++; if (bus.WR_DATA !== 32'h0) $display("FAIL rst_wr_data got %h want 0", bus.WR_DATA); else passed++;
    total++; if (bus.GRANT_ID !== 3'd0) $display("FAIL rst_grant_id got %0d want 0", bus.GRANT_ID); else passed++;
    total++; if (STALL_CNT !== 16'd0) $display("FAIL rst_stall got %0d want 0", STALL_CNT); else passed++;
    bus.REQ_VALID = '0;
    step();
    RESET = 1'b0;
  endtask

  task automatic test_single;
    do_reset();
    set_req(FWB_REQ_FPU, 5'd5, 32'h3F80_0000);
    bus.REQ_VALID = 3'b001;
    #1;
    total++; if (bus.REQ_READY !== 3'b001) $display("FAIL single_ready got %b want 001", bus.REQ_READY); else passed++;
    step();
    bus.REQ_VALID = 3'b000;
    total++; if (bus.WR_EN !== 1'b1) $display("FAIL single_wr_en got %b want 1", bus.WR_EN); else passed++;
    total++; if (bus.WR_ADDR !== 5'd5) $display("FAIL single_wr_addr got %0d want 5", bus.WR_ADDR); else passed++;
    total++; if (bus.WR_DATA !== 32'h3F80_0000) $display("FAIL single_wr_data got %h want 3f800000", bus.WR_DATA); else passed++;
    total++; if (bus.GRANT_ID !== 3'd0) $display("FAIL single_grant_id got %0d want 0", bus.GRANT_ID); else passed++;
    step();
    total++; if (bus.WR_EN !== 1'b0) $display("FAIL single_idle_wr_en got %b want 0", bus.WR_EN); else passed++;
    total++; if (bus.WR_ADDR !== 5'd5) $display("FAIL single_hold_addr got %0d want 5", bus.WR_ADDR); else passed++;
    total++; if (STALL_CNT !== 16'd0) $display("FAIL single_stall got %0d want 0", STALL_CNT); else passed++;
  endtask

  task automatic test_back_to_back;
    do_reset();
    set_req(0, 5'd1, 32'hA000_0000);
    set_req(1, 5'd2, 32'hA000_0001);
    set_req(2, 5'd3, 32'hA000_0002);
    bus.REQ_VALID = 3'b111;
    #1;
    total++; if (bus.REQ_READY !== 3'b001) $display("FAIL b2b_ready0 got %b want 001", bus.REQ_READY); else passed++;
    step();
    bus.REQ_VALID = 3'b110;
    total++; if (bus.WR_ADDR !== 5'd1 || bus.GRANT_ID !== 3'd0) $display("FAIL b2b_wr0 got addr %0d id %0d want 1/0", bus.WR_ADDR, bus.GRANT_ID); else passed++;
    #1;
    total++; if (bus.REQ_READY !== 3'b010) $display("FAIL b2b_ready1 got %b want 010", bus.REQ_READY); else passed++;
    step();
    bus.REQ_VALID = 3'b100;
    total++; if (bus.WR_ADDR !== 5'd2 || bus.GRANT_ID !== 3'd1) $display("FAIL b2b_wr1 got addr %0d id %0d want 2/1", bus.WR_ADDR, bus.GRANT_ID); else passed++;
    #1;
    total++; if (bus.REQ_READY !== 3'b100) $display("FAIL b2b_ready2 got %b want 100", bus.REQ_READY); else passed++;
    step();
    set_req(0, 5'd1, 32'hB000_0000);
    bus.REQ_VALID = 3'b001;
    total++; if (bus.WR_ADDR !== 5'd3 || bus.GRANT_ID !== 3'd2 || bus.WR_DATA !== 32'hA000_0002) $display("FAIL b2b_wr2 got addr %0d id %0d data %h want 3/2/a0000002", bus.WR_ADDR, bus.GRANT_ID, bus.WR_DATA); else passed++;
    total++; if (STALL_CNT !== 16'd3) $display("FAIL b2b_stall got %0d want 3", STALL_CNT); else passed++;
    #1;
    total++; if (bus.REQ_READY !== 3'b001) $display("FAIL b2b_ready_again got %b want 001", bus.REQ_READY); else passed++;
    step();
    bus.REQ_VALID = 3'b000;
    total++; if (bus.WR_EN !== 1'b1 || bus.GRANT_ID !== 3'd0 || bus.WR_DATA !== 32'hB000_0000) $display("FAIL b2b_wr3 got en %b id %0d data %h want 1/0/b0000000", bus.WR_EN, bus.GRANT_ID, bus.WR_DATA); else passed++;
  endtask

  task automatic test_wrap;
    do_reset();
    set_req(0, 5'd10, 32'h0000_0010);
    set_req(1, 5'd11, 32'h0000_0011);
    set_req(2, 5'd12, 32'h0000_0012);
    bus.REQ_VALID = 3'b011;
    step();
    bus.REQ_VALID = 3'b010;
    step();
    bus.REQ_VALID = 3'b101;
    #1;
    total++; if (bus.REQ_READY !== 3'b100) $display("FAIL wrap_ready2 got %b want 100", bus.REQ_READY); else passed++;
    step();
    bus.REQ_VALID = 3'b001;
    total++; if (bus.GRANT_ID !== 3'd2 || bus.WR_ADDR !== 5'd12) $display("FAIL wrap_wr2 got id %0d addr %0d want 2/12", bus.GRANT_ID, bus.WR_ADDR); else passed++;
    #1;
    total++; if (bus.REQ_READY !== 3'b001) $display("FAIL wrap_ready0 got %b want 001", bus.REQ_READY); else passed++;
    step();
    bus.REQ_VALID = 3'b000;
    total++; if (bus.GRANT_ID !== 3'd0 || bus.WR_ADDR !== 5'd10) $display("FAIL wrap_wr0 got id %0d addr %0d want 0/10", bus.GRANT_ID, bus.WR_ADDR); else passed++;
    total++; if (STALL_CNT !== 16'd2) $display("FAIL wrap_stall got %0d want 2", STALL_CNT); else passed++;
  endtask

  task automatic test_flush;
    do_reset();
    FLUSH = 1'b1;
    set_req(1, 5'd4, 32'h0000_0044);
    bus.REQ_VALID = 3'b010;
    #1;
    total++; if (bus.REQ_READY !== 3'b000) $display("FAIL flush_ready_a got %b want 000", bus.REQ_READY); else passed++;
    step();
    total++; if (bus.WR_EN !== 1'b0 || STALL_CNT !== 16'd1) $display("FAIL flush_cyc1 got en %b stall %0d want 0/1", bus.WR_EN, STALL_CNT); else passed++;
    total++; if (bus.REQ_READY !== 3'b000) $display("FAIL flush_ready_b got %b want 000", bus.REQ_READY); else passed++;
    step();
    total++; if (bus.WR_EN !== 1'b0 || STALL_CNT !== 16'd2) $display("FAIL flush_cyc2 got en %b stall %0d want 0/2", bus.WR_EN, STALL_CNT); else passed++;
    FLUSH = 1'b0;
    #1;
    total++; if (bus.REQ_READY !== 3'b010) $display("FAIL flush_release_ready got %b want 010", bus.REQ_READY); else passed++;
    step();
    bus.REQ_VALID = 3'b000;
    FLUSH = 1'b1;
    #1;
    total++; if (bus.WR_EN !== 1'b1 || bus.GRANT_ID !== 3'd1 || bus.WR_ADDR !== 5'd4) $display("FAIL flush_no_squash got en %b id %0d addr %0d want 1/1/4", bus.WR_EN, bus.GRANT_ID, bus.WR_ADDR); else passed++;
    total++; if (STALL_CNT !== 16'd2) $display("FAIL flush_stall_final got %0d want 2", STALL_CNT); else passed++;
    step();
    FLUSH = 1'b0;
  endtask

  task automatic test_mid_reset;
    do_reset();
    set_req(0, 5'd7, 32'h0000_0077);
    bus.REQ_VALID = 3'b001;
    step();
    total++; if (bus.WR_EN !== 1'b1 || bus.WR_ADDR !== 5'd7) $display("FAIL mrst_pre got en %b addr %0d want 1/7", bus.WR_EN, bus.WR_ADDR); else passed++;
    RESET = 1'b1;
    set_req(1, 5'd8, 32'h0000_0088);
    set_req(2, 5'd9, 32'h0000_0099);
    bus.REQ_VALID = 3'b110;
    #1;
    total++; if (bus.REQ_READY !== 3'b000) $display("FAIL mrst_ready got %b want 000", bus.REQ_READY); else passed++;
    step();
    total++; if (bus.WR_EN !== 1'b0 || bus.WR_ADDR !== 5'd0 || STALL_CNT !== 16'd0) $display("FAIL mrst_drop got en %b addr %0d stall %0d want 0/0/0", bus.WR_EN, bus.WR_ADDR, STALL_CNT); else passed++;
    RESET = 1'b0;
    #1;
    total++; if (bus.REQ_READY !== 3'b010) $display("FAIL mrst_restart_ready got %b want 010", bus.REQ_READY); else passed++;
    step();
    bus.REQ_VALID = 3'b100;
    total++; if (bus.WR_EN !== 1'b1 || bus.GRANT_ID !== 3'd1 || bus.WR_DATA !== 32'h0000_0088) $display("FAIL mrst_first got en %b id %0d data %h want 1/1/88", bus.WR_EN, bus.GRANT_ID, bus.WR_DATA); else passed++;
    total++; if (STALL_CNT !== 16'd1) $display("FAIL mrst_stall got %0d want 1", STALL_CNT); else passed++;
    step();
    bus.REQ_VALID = 3'b000;
    total++; if (bus.GRANT_ID !== 3'd2 || bus.WR_ADDR !== 5'd9) $display("FAIL mrst_second got id %0d addr %0d want 2/9", bus.GRANT_ID, bus.WR_ADDR); else passed++;
  endtask

  task automatic test_saturate;
    do_reset();
    FLUSH2 = 1'b1;
    bus2.REQ_ADDR = {5'd3, 5'd2, 5'd1};
    bus2.REQ_DATA = {32'hC2, 32'hC1, 32'hC0};
    bus2.REQ_VALID = 3'b011;
    for (int k = 1; k <= 10; k++) begin
      step();
      if (k == 7) begin
        total++; if (STALL_CNT2 !== 4'd14) $display("FAIL sat_k7 got %0d want 14", STALL_CNT2); else passed++;
      end
      if (k == 8) begin
        total++; if (STALL_CNT2 !== 4'd15) $display("FAIL sat_k8 got %0d want 15", STALL_CNT2); else passed++;
      end
      if (k == 10) begin
        total++; if (STALL_CNT2 !== 4'd15) $display("FAIL sat_k10 got %0d want 15", STALL_CNT2); else passed++;
      end
    end
    FLUSH2 = 1'b0;
    #1;
    total++; if (bus2.REQ_READY !== 3'b001) $display("FAIL sat_release_ready got %b want 001", bus2.REQ_READY); else passed++;
    step();
    bus2.REQ_VALID = 3'b000;
    total++; if (bus2.WR_EN !== 1'b1 || STALL_CNT2 !== 4'd15) $display("FAIL sat_after got en %b stall %0d want 1/15", bus2.WR_EN, STALL_CNT2); else passed++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_wrap();
    test_flush();
    test_mid_reset();
    test_saturate();
    step();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
